// File: rtl/uart_pkt_pkg.sv
// Shared constants and state encoding for the UART packet wrappers.
// Both the transmit and receive ends import this package.
package uart_pkt_pkg;

    localparam logic [7:0] SOF         = 8'h8F;
    localparam logic [7:0] CRC8_POLY   = 8'h1D;
    localparam logic [7:0] CRC8_INIT   = 8'hFF;
    localparam int         MAX_PAYLOAD = 10;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ADDR,
        COUNT,
        DATA,
        CRC
    } tx_state_t;

endpackage

// File: rtl/crc8_j1850_serial.sv
// Bit-serial CRC-8 (SAE J1850): a byte is XORed in, then shifted out over 8 cycles.
// The receive wrapper uses the same block, so both ends agree bit for bit.
module crc8_j1850_serial
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY,
    parameter logic [7:0] INIT = CRC8_INIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic [7:0] crc,
    output logic       busy
);

    logic [3:0] bit_cnt;
    logic [7:0] shifted;

    assign shifted = crc[7] ? ({crc[6:0], 1'b0} ^ POLY) : {crc[6:0], 1'b0};
    assign busy    = (bit_cnt != 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc     <= INIT;
            bit_cnt <= 4'd0;
        end else if (init) begin
            crc     <= INIT;
            bit_cnt <= 4'd0;
        end else if (load) begin
            crc     <= crc ^ data_in;
            bit_cnt <= 4'd8;
        end else if (busy) begin
            crc     <= shifted;
            bit_cnt <= bit_cnt - 4'd1;
        end
    end

endmodule

// File: rtl/uart_packet_wrapper_tx.sv
// Frames SOF, address, length, payload and CRC-8 for the byte-wide UART TX engine.
// A byte goes out only when the UART is ready and the CRC engine has finished the previous one.
module uart_packet_wrapper_tx
    import uart_pkt_pkg::*;
#(
    parameter int         MAX_PAYLOAD = uart_pkt_pkg::MAX_PAYLOAD,
    parameter logic [7:0] POLY        = CRC8_POLY,
    parameter logic [7:0] CRC_INIT    = CRC8_INIT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     uartDisabled,
    input  logic                     tx_start,
    input  logic [6:0]               tx_address,
    input  logic [8*MAX_PAYLOAD-1:0] tx_data,
    input  logic [7:0]               tx_payload_len,
    input  logic                     uart_tx_ready,
    output logic [7:0]               uart_tx_data,
    output logic                     uart_tx_val,
    output logic                     tx_busy,
    output logic                     tx_done,
    output logic                     tx_error
);

    tx_state_t state, next_state;

    logic [6:0]               addr_q;
    logic [7:0]               len_q;
    logic [8*MAX_PAYLOAD-1:0] data_q;
    logic [7:0]               idx;

    logic       start_req;
    logic       bad_len;
    logic       accept;
    logic       abort;
    logic       issue;
    logic       crc_load;
    logic       crc_busy;
    logic [7:0] crc_val;
    logic [7:0] tx_byte;

    crc8_j1850_serial #(
        .POLY (POLY),
        .INIT (CRC_INIT)
    ) u_crc (
        .clk     (clk),
        .reset   (reset),
        .init    (accept),
        .load    (crc_load),
        .data_in (tx_byte),
        .crc     (crc_val),
        .busy    (crc_busy)
    );

    always_comb begin
        start_req = (state == IDLE) && tx_start && !uartDisabled;
        bad_len   = (tx_payload_len == 8'd0) ||
                    (tx_payload_len > 8'(MAX_PAYLOAD));
        accept    = start_req && !bad_len;
        abort     = (state != IDLE) && uartDisabled;
        issue     = (state != IDLE) && !uartDisabled &&
                    uart_tx_ready && !crc_busy;
        crc_load  = issue && (state != CRC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (accept) next_state = HDR;
            HDR:   if (issue) next_state = ADDR;
            ADDR:  if (issue) next_state = COUNT;
            COUNT: if (issue) next_state = DATA;
            DATA:  if (issue && idx == 8'd0) next_state = CRC;
            CRC:   if (issue) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    always_comb begin
        tx_byte = 8'h00;
        unique case (state)
            HDR:   tx_byte = SOF;
            ADDR:  tx_byte = {1'b0, addr_q};
            COUNT: tx_byte = len_q;
            DATA:  tx_byte = data_q[{idx, 3'b000} +: 8];
            CRC:   tx_byte = crc_val;
            default: tx_byte = 8'h00;
        endcase
    end

    assign uart_tx_val  = issue;
    assign uart_tx_data = issue ? tx_byte : 8'h00;
    assign tx_busy      = (state != IDLE);

    // Payload index counts down so the MSB end of tx_data leaves first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            len_q  <= '0;
            data_q <= '0;
            idx    <= '0;
        end else if (accept) begin
            addr_q <= tx_address;
            len_q  <= tx_payload_len;
            data_q <= tx_data;
            idx    <= tx_payload_len - 8'd1;
        end else if (issue && state == DATA) begin
            idx    <= idx - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            tx_done  <= issue && (state == CRC);
            tx_error <= (start_req && bad_len) || abort;
        end
    end

endmodule

// File: tb/tb_uart_packet_wrapper_tx.sv
// Scoreboard bench for uart_packet_wrapper_tx: stimulus queues expected bytes,
// a forked monitor pops and compares on every uart_tx_val strobe.
module tb_uart_packet_wrapper_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        uartDisabled;
    logic        tx_start;
    logic [6:0]  tx_address;
    logic [79:0] tx_data;
    logic [7:0]  tx_payload_len;
    logic        uart_tx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_val;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_error;

    uart_packet_wrapper_tx dut (
        .clk            (clk),
        .reset          (reset),
        .uartDisabled   (uartDisabled),
        .tx_start       (tx_start),
        .tx_address     (tx_address),
        .tx_data        (tx_data),
        .tx_payload_len (tx_payload_len),
        .uart_tx_ready  (uart_tx_ready),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_val    (uart_tx_val),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .tx_error       (tx_error)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int checks    = 0;
    int errors    = 0;
    int strobes   = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int busy_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_model(input logic [7:0] b[$]);
        logic [7:0] c;
        c = 8'hFF;
        foreach (b[i]) begin
            c = c ^ b[i];
            for (int k = 0; k < 8; k++)
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h1D) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic monitor();
        bit have_last = 0;
        int since = 0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_last = 0;
                continue;
            end
            since++;
            if (uart_tx_val) begin
                strobes++;
                check("ready_at_strobe", uart_tx_ready, 1);
                if (have_last) begin
                    checks++;
                    if (since < 9) begin
                        errors++;
                        $display("FAIL gap: got %0d cycles required >=9", since);
                    end
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got %0h required none",
                             uart_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", uart_tx_data, e);
                end
                have_last = 1;
                since = 0;
            end
            if (!tx_busy) have_last = 0;
            if (tx_done) begin
                done_cnt++;
                check("done_busy_low", tx_busy, 0);
            end
            if (tx_error) err_cnt++;
            if (tx_busy) busy_cnt++;
        end
    endtask

    task automatic send(input logic [6:0] a, input logic [7:0] len,
                        input logic [79:0] d, input int n_push);
        logic [7:0] b[$];
        if (n_push > 0) begin
            b.push_back(8'h8F);
            b.push_back({1'b0, a});
            b.push_back(len);
            for (int i = 0; i < int'(len); i++)
                b.push_back(d[8*(int'(len)-1-i) +: 8]);
            b.push_back(crc_model(b));
            for (int i = 0; i < n_push; i++) exp_q.push_back(b[i]);
        end
        @(posedge clk);
        #1;
        tx_start       = 1'b1;
        tx_address     = a;
        tx_payload_len = len;
        tx_data        = d;
        @(posedge clk);
        #1;
        tx_start       = 1'b0;
        tx_address     = 7'h7F;
        tx_payload_len = 8'hEE;
        tx_data        = {5{16'hDEAD}};
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && tx_busy; i++) @(negedge clk);
        check("idle_timeout", tx_busy, 0);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        for (int i = 0; i < budget && strobes < target; i++) @(negedge clk);
        check("strobe_timeout", strobes >= target, 1);
    endtask

    int s0, d0, e0, b0;

    task automatic snap();
        s0 = strobes;
        d0 = done_cnt;
        e0 = err_cnt;
        b0 = busy_cnt;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        uartDisabled   = 1'b0;
        tx_start       = 1'b0;
        tx_address     = '0;
        tx_data        = '0;
        tx_payload_len = '0;
        uart_tx_ready  = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check("rst_val", uart_tx_val, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_error, 0);
        check("rst_data", uart_tx_data, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single byte payload, hand-computed frame
        snap();
        exp_q.push_back(8'h8F);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h8F);
        send(7'h01, 8'd1, 80'h55, 0);
        check("t1_latency_val", uart_tx_val, 1);
        check("t1_latency_sof", uart_tx_data, 8'h8F);
        wait_idle(200);
        repeat (3) @(negedge clk);
        check("t1_strobes", strobes - s0, 5);
        check("t1_done", done_cnt - d0, 1);
        check("t1_err", err_cnt - e0, 0);
        check("t1_busy_cycles", busy_cnt - b0, 37);
        check("t1_q_empty", exp_q.size(), 0);

        // 2: full payload
        snap();
        send(7'h5A, 8'd10, 80'h00112233445566778899, 14);
        wait_idle(400);
        repeat (3) @(negedge clk);
        check("t2_strobes", strobes - s0, 14);
        check("t2_done", done_cnt - d0, 1);
        check("t2_busy_cycles", busy_cnt - b0, 118);
        check("t2_q_empty", exp_q.size(), 0);

        // 3: illegal lengths
        snap();
        send(7'h02, 8'd0, 80'h0, 0);
        repeat (4) @(negedge clk);
        check("t3_err_len0", err_cnt - e0, 1);
        send(7'h02, 8'd11, 80'h0, 0);
        repeat (4) @(negedge clk);
        check("t3_err_len11", err_cnt - e0, 2);
        check("t3_strobes", strobes - s0, 0);
        check("t3_busy", busy_cnt - b0, 0);

        // 4: ready low for 50 cycles after the header byte
        snap();
        send(7'h33, 8'd2, 80'hC0DE, 6);
        @(posedge clk);
        #1;
        uart_tx_ready = 1'b0;
        repeat (50) @(negedge clk);
        check("t4_stalled", strobes - s0, 1);
        check("t4_busy_held", tx_busy, 1);
        @(posedge clk);
        #1;
        uart_tx_ready = 1'b1;
        wait_idle(300);
        repeat (3) @(negedge clk);
        check("t4_strobes", strobes - s0, 6);
        check("t4_done", done_cnt - d0, 1);
        check("t4_q_empty", exp_q.size(), 0);

        // 5: abort in DATA, then start while disabled
        snap();
        send(7'h03, 8'd4, 80'hA1B2C3D4, 5);
        wait_strobes(s0 + 5, 200);
        @(posedge clk);
        #1;
        uartDisabled = 1'b1;
        repeat (30) @(negedge clk);
        check("t5_strobes", strobes - s0, 5);
        check("t5_err", err_cnt - e0, 1);
        check("t5_done", done_cnt - d0, 0);
        check("t5_idle", tx_busy, 0);
        snap();
        send(7'h04, 8'd2, 80'h1234, 0);
        repeat (20) @(negedge clk);
        check("t5_ign_strobes", strobes - s0, 0);
        check("t5_ign_err", err_cnt - e0, 0);
        check("t5_ign_busy", busy_cnt - b0, 0);
        @(posedge clk);
        #1;
        uartDisabled = 1'b0;

        // 6: reset mid-DATA, then a clean packet
        snap();
        send(7'h10, 8'd3, 80'h010203, 4);
        wait_strobes(s0 + 4, 200);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_val", uart_tx_val, 0);
        check("t6_rst_busy", tx_busy, 0);
        check("t6_rst_data", uart_tx_data, 0);
        check("t6_rst_err", tx_error, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6_q_empty_rst", exp_q.size(), 0);
        snap();
        send(7'h22, 8'd2, 80'hBEEF, 6);
        wait_idle(300);
        repeat (3) @(negedge clk);
        check("t6_strobes", strobes - s0, 6);
        check("t6_done", done_cnt - d0, 1);
        check("t6_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
